vote_session_ctrl: RTL and testbench

VOTE_SESSION_CTRL -- requirements
Module: vote_session_ctrl

---
 rtl/vote_session_if.sv | 23 ++
 rtl/vote_session_ctrl.sv | 149 ++++++++++++++
 tb/tb_vote_session_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vote_session_if.sv
// Ballot signal bundle between the presiding-officer side and the session controller.
// The master side drives the operator inputs; the controller is the slave.
interface vote_session_if;
   logic       mode;
   logic       enable;
   logic [3:0] button;
   logic [3:0] valid_vote;
   logic       ready;
   logic       busy;
   logic       reject;
   logic [7:0] cast_count;
   logic [7:0] reject_count;

   modport master (
      output mode, enable, button,
      input  valid_vote, ready, busy, reject, cast_count, reject_count
   );

   modport slave (
      input  mode, enable, button,
      output valid_vote, ready, busy, reject, cast_count, reject_count
   );
endinterface

// File: rtl/vote_session_ctrl.sv
// Voting-session controller: arms one ballot, debounces a single candidate button,
// emits a one-hot cast pulse, waits for release, then locks out for a fixed time.
// Multi-button presses while armed are rejected once per press episode.
module vote_session_ctrl #(
   parameter int HOLD_CYCLES = 10,
   parameter int LOCK_CYCLES = 100
) (
   input logic           clock,
   input logic           reset,
   vote_session_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      DEBOUNCE,
      CAST,
      RELEASE,
      LOCKOUT
   } state_t;

   // Both limits live in the 16-bit counter domain so the compares cannot overflow.
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);

   state_t      state, state_next;
   logic [3:0]  sync_1, btn_s;
   logic [3:0]  latched, latched_next;
   logic [15:0] cnt, cnt_next;
   logic        reject_hold, reject_hold_next;
   logic        one_hot, multi;

   logic [3:0]  valid_vote_q, valid_vote_next;
   logic        ready_q, ready_next;
   logic        busy_q, busy_next;
   logic        reject_q, reject_next;
   logic [7:0]  cast_count_q, cast_count_next;
   logic [7:0]  reject_count_q, reject_count_next;

   assign one_hot = (btn_s != 4'd0) && ((btn_s & (btn_s - 4'd1)) == 4'd0);
   assign multi   = (btn_s != 4'd0) && !one_hot;

   assign bus.valid_vote   = valid_vote_q;
   assign bus.ready        = ready_q;
   assign bus.busy         = busy_q;
   assign bus.reject       = reject_q;
   assign bus.cast_count   = cast_count_q;
   assign bus.reject_count = reject_count_q;

   // Two-flop synchronizer for the raw asynchronous buttons.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_1 <= 4'd0;
         btn_s  <= 4'd0;
      end else begin
         sync_1 <= bus.button;
         btn_s  <= sync_1;
      end
   end

   // State, counter and registered outputs all update together so outputs track the state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         latched        <= 4'd0;
         cnt            <= 16'd0;
         reject_hold    <= 1'b0;
         valid_vote_q   <= 4'd0;
         ready_q        <= 1'b0;
         busy_q         <= 1'b0;
         reject_q       <= 1'b0;
         cast_count_q   <= 8'd0;
         reject_count_q <= 8'd0;
      end else begin
         state          <= state_next;
         latched        <= latched_next;
         cnt            <= cnt_next;
         reject_hold    <= reject_hold_next;
         valid_vote_q   <= valid_vote_next;
         ready_q        <= ready_next;
         busy_q         <= busy_next;
         reject_q       <= reject_next;
         cast_count_q   <= cast_count_next;
         reject_count_q <= reject_count_next;
      end
   end

   // Next-state logic; output next-values are derived from the state being entered.
   always_comb begin
      state_next        = state;
      latched_next      = latched;
      cnt_next          = cnt;
      reject_hold_next  = reject_hold && (btn_s != 4'd0);
      reject_next       = 1'b0;
      cast_count_next   = cast_count_q;
      reject_count_next = reject_count_q;

      case (state)
         IDLE: begin
            if (bus.enable && !bus.mode) state_next = ARMED;
         end
         ARMED: begin
            if (bus.mode) begin
               state_next = IDLE;
            end else if (one_hot) begin
               latched_next = btn_s;
               cnt_next     = 16'd1;
               state_next   = DEBOUNCE;
            end else if (multi && !reject_hold) begin
               reject_next      = 1'b1;
               reject_hold_next = 1'b1;
               if (reject_count_q != 8'hFF) reject_count_next = reject_count_q + 8'd1;
            end
         end
         DEBOUNCE: begin
            if (bus.mode) begin
               state_next = IDLE;
            end else if (btn_s != latched) begin
               cnt_next   = 16'd0;
               state_next = ARMED;
            end else if (cnt == HOLD_LAST) begin
               cast_count_next = cast_count_q + 8'd1;
               state_next      = CAST;
            end else begin
               cnt_next = cnt + 16'd1;
            end
         end
         CAST: begin
            state_next = RELEASE;
         end
         RELEASE: begin
            if (btn_s == 4'd0) begin
               cnt_next   = 16'd0;
               state_next = LOCKOUT;
            end
         end
         LOCKOUT: begin
            if (cnt == LOCK_LAST) state_next = IDLE;
            else                  cnt_next   = cnt + 16'd1;
         end
         default: state_next = IDLE;
      endcase

      valid_vote_next = (state_next == CAST) ? latched_next : 4'd0;
      ready_next      = (state_next == ARMED);
      busy_next       = (state_next == LOCKOUT);
   end

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for the voting-session controller: directed ballots plus randomized ballots,
// with expectations computed from hold/lockout arithmetic and pulse counting.
module tb_vote_session_ctrl;
   localparam int HOLD = 10;
   localparam int LOCK = 100;

   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   vote_session_if bus();

   vote_session_ctrl #(.HOLD_CYCLES(HOLD), .LOCK_CYCLES(LOCK)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   // Rising-edge counter used as the time base for latency expectations.
   always @(posedge clock) cyc <= cyc + 1;

   int         voteCount    = 0;
   logic [3:0] lastVote     = 4'd0;
   int         lastVoteCyc  = 0;
   int         rejectPulses = 0;
   int         lastRejCyc   = 0;
   int         busyRun      = 0;
   int         lastBusyLen  = 0;
   int         busyStartCyc = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Observes pulses and busy windows on the falling edge, away from DUT updates.
   always @(negedge clock) begin
      if (bus.valid_vote !== 4'd0) begin
         voteCount++;
         lastVote    = bus.valid_vote;
         lastVoteCyc = cyc;
         checkOutput("vote_onehot", 32'($countones(bus.valid_vote)), 1);
      end
      if (bus.reject === 1'b1) begin
         rejectPulses++;
         lastRejCyc = cyc;
      end
      if (bus.busy === 1'b1) begin
         if (busyRun == 0) busyStartCyc = cyc;
         busyRun++;
      end else if (busyRun != 0) begin
         lastBusyLen = busyRun;
         busyRun     = 0;
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] mask, input int hold, output int pressCyc);
      bus.button = mask;
      pressCyc   = cyc;
      step(hold);
      bus.button = 4'd0;
   endtask

   task automatic armBallot();
      bus.enable = 1'b1;
      step(1);
      bus.enable = 1'b0;
      checkOutput("arm_ready", 32'(bus.ready), 1);
   endtask

   initial begin
      int         p, v0, r0, hold, kind, expCast, expRej;
      logic [3:0] mask;
      bit         armed;

      reset      = 1'b1;
      bus.mode   = 1'b0;
      bus.enable = 1'b0;
      bus.button = 4'd0;
      expCast    = 0;
      expRej     = 0;
      step(3);
      checkOutput("rst_valid", 32'(bus.valid_vote), 0);
      checkOutput("rst_ready", 32'(bus.ready), 0);
      checkOutput("rst_busy", 32'(bus.busy), 0);
      checkOutput("rst_reject", 32'(bus.reject), 0);
      checkOutput("rst_cast_cnt", 32'(bus.cast_count), 0);
      checkOutput("rst_rej_cnt", 32'(bus.reject_count), 0);
      reset = 1'b0;
      step(2);

      // Basic cast: 0010 held 20 cycles, pulse 2 sync + HOLD edges later.
      armBallot();
      v0 = voteCount;
      applyStimulus(4'b0010, 20, p);
      step(5);
      bus.enable = 1'b1;
      step(1);
      bus.enable = 1'b0;
      step(LOCK);
      expCast++;
      checkOutput("c1_votes", 32'(voteCount - v0), 1);
      checkOutput("c1_value", 32'(lastVote), 32'(4'b0010));
      checkOutput("c1_latency", 32'(lastVoteCyc - p), 32'(HOLD + 2));
      checkOutput("c1_cast_cnt", 32'(bus.cast_count), 32'(expCast));
      checkOutput("c1_busy_start", 32'(busyStartCyc - p), 23);
      checkOutput("c1_busy_len", 32'(lastBusyLen), 32'(LOCK));
      checkOutput("c1_enable_ignored", 32'(bus.ready), 0);

      // Unarmed press must not cast.
      v0 = voteCount;
      applyStimulus(4'b0001, 15, p);
      step(10);
      checkOutput("unarmed_votes", 32'(voteCount - v0), 0);
      checkOutput("unarmed_ready", 32'(bus.ready), 0);

      // Multi-button reject, then a valid single press.
      armBallot();
      v0 = voteCount;
      r0 = rejectPulses;
      applyStimulus(4'b0101, 6, p);
      step(5);
      expRej++;
      checkOutput("rej_pulses", 32'(rejectPulses - r0), 1);
      checkOutput("rej_time", 32'(lastRejCyc - p), 3);
      checkOutput("rej_cnt", 32'(bus.reject_count), 32'(expRej));
      checkOutput("rej_votes", 32'(voteCount - v0), 0);
      checkOutput("rej_ready", 32'(bus.ready), 1);
      applyStimulus(4'b1000, 14, p);
      step(LOCK + 10);
      expCast++;
      checkOutput("rej_then_vote", 32'(lastVote), 32'(4'b1000));
      checkOutput("rej_then_cnt", 32'(bus.cast_count), 32'(expCast));

      // Short press: released before hold completes.
      armBallot();
      v0 = voteCount;
      applyStimulus(4'b0001, 5, p);
      step(5);
      checkOutput("short_votes", 32'(voteCount - v0), 0);
      checkOutput("short_ready", 32'(bus.ready), 1);

      // Mode switch mid-debounce aborts the ballot.
      v0 = voteCount;
      bus.button = 4'b0100;
      step(7);
      bus.mode = 1'b1;
      step(20);
      bus.mode   = 1'b0;
      bus.button = 4'd0;
      step(5);
      checkOutput("mode_votes", 32'(voteCount - v0), 0);
      checkOutput("mode_ready", 32'(bus.ready), 0);

      // Reset mid-debounce aborts with no cast.
      armBallot();
      v0 = voteCount;
      bus.button = 4'b0100;
      step(6);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(20);
      bus.button = 4'd0;
      step(5);
      expCast = 0;
      expRej  = 0;
      checkOutput("rstdeb_votes", 32'(voteCount - v0), 0);
      checkOutput("rstdeb_ready", 32'(bus.ready), 0);

      // Reset during lockout clears everything; re-arming works.
      armBallot();
      applyStimulus(4'b0001, 12, p);
      step(10);
      checkOutput("rstlock_busy_before", 32'(bus.busy), 1);
      reset = 1'b1;
      step(1);
      checkOutput("rstlock_busy", 32'(bus.busy), 0);
      checkOutput("rstlock_cast_cnt", 32'(bus.cast_count), 0);
      checkOutput("rstlock_rej_cnt", 32'(bus.reject_count), 0);
      checkOutput("rstlock_ready", 32'(bus.ready), 0);
      reset = 1'b0;
      step(2);
      armBallot();
      v0 = voteCount;
      applyStimulus(4'b0010, 12, p);
      step(LOCK + 10);
      expCast = 1;
      checkOutput("rstlock_revote", 32'(voteCount - v0), 1);
      checkOutput("rstlock_recnt", 32'(bus.cast_count), 32'(expCast));

      // Randomized ballots against hold/lockout arithmetic.
      armed = 1'b0;
      for (int i = 0; i < 24; i++) begin
         if (!armed) begin
            armBallot();
            armed = 1'b1;
         end
         kind = $urandom_range(0, 2);
         v0   = voteCount;
         r0   = rejectPulses;
         if (kind == 0) begin
            do mask = 4'($urandom_range(0, 15)); while ($countones(mask) < 2);
            hold = $urandom_range(1, 6);
            applyStimulus(mask, hold, p);
            step(5);
            expRej = (expRej < 255) ? expRej + 1 : 255;
            checkOutput("rnd_rej_pulses", 32'(rejectPulses - r0), 1);
            checkOutput("rnd_rej_cnt", 32'(bus.reject_count), 32'(expRej));
            checkOutput("rnd_rej_ready", 32'(bus.ready), 1);
         end else begin
            mask = 4'(1 << $urandom_range(0, 3));
            hold = $urandom_range(1, 2 * HOLD);
            applyStimulus(mask, hold, p);
            step(LOCK + 10);
            if (hold >= HOLD) begin
               expCast = (expCast + 1) % 256;
               armed   = 1'b0;
               checkOutput("rnd_votes", 32'(voteCount - v0), 1);
               checkOutput("rnd_value", 32'(lastVote), 32'(mask));
               checkOutput("rnd_latency", 32'(lastVoteCyc - p), 32'(HOLD + 2));
               checkOutput("rnd_busy_start", 32'(busyStartCyc - p),
                           32'((hold + 3 > HOLD + 4) ? hold + 3 : HOLD + 4));
               checkOutput("rnd_busy_len", 32'(lastBusyLen), 32'(LOCK));
               checkOutput("rnd_idle_ready", 32'(bus.ready), 0);
            end else begin
               checkOutput("rnd_novote", 32'(voteCount - v0), 0);
               checkOutput("rnd_still_armed", 32'(bus.ready), 1);
            end
            checkOutput("rnd_cast_cnt", 32'(bus.cast_count), 32'(expCast));
         end
      end

      // 256 casts wrap the cast counter back to its starting value.
      if (armed) begin
         bus.mode = 1'b1;
         step(2);
         bus.mode = 1'b0;
         step(1);
      end
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(2);
      v0 = voteCount;
      for (int i = 0; i < 256; i++) begin
         armBallot();
         applyStimulus(4'(1 << (i % 4)), HOLD + 2, p);
         step(LOCK + 10);
      end
      checkOutput("wrap_votes", 32'(voteCount - v0), 256);
      checkOutput("wrap_cast_cnt", 32'(bus.cast_count), 0);

      // 300 rejects saturate the reject counter.
      armBallot();
      r0 = rejectPulses;
      for (int i = 0; i < 300; i++) begin
         applyStimulus(4'b0101, 2, p);
         step(4);
      end
      checkOutput("sat_pulses", 32'(rejectPulses - r0), 300);
      checkOutput("sat_rej_cnt", 32'(bus.reject_count), 255);
      checkOutput("sat_ready", 32'(bus.ready), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
